// File: rtl/byte_accumulator.sv
// Queued 8-bit accumulator: operations wait in a small FIFO and execute one per cycle.
// Also holds the two's-complement helper that is shared with the upstream datapath.

module byte_negate (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = ~a + 8'd1;
endmodule

module byte_accumulator #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [1:0]                 op,
  input  logic [7:0]                 operand,
  input  logic                       hold,
  output logic [7:0]                 acc,
  output logic                       res_valid,
  output logic                       flag_z,
  output logic                       flag_n,
  output logic                       flag_c,
  output logic                       flag_v,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpAdd  = 2'b01,
    OpSub  = 2'b10,
    OpNeg  = 2'b11
  } op_e;

  // FIFO storage and control
  logic [1:0]    op_mem   [DEPTH];
  logic [7:0]    opnd_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Architectural state
  logic [7:0] acc_q;
  logic       res_valid_q;
  logic       flag_z_q, flag_n_q, flag_c_q, flag_v_q;

  logic push, pop;
  logic full;

  assign full     = (count_q == CW'(DEPTH));
  assign op_ready = !reset && !full;
  assign push     = op_valid && op_ready;
  assign pop      = !hold && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= op;
      opnd_mem[wr_ptr_q] <= operand;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Execution datapath on the FIFO head
  op_e        head_op;
  logic [7:0] head_opnd;
  logic [7:0] neg_acc;
  logic [8:0] sum;
  logic [7:0] r;
  logic       c, v;

  assign head_op   = op_e'(op_mem[rd_ptr_q]);
  assign head_opnd = opnd_mem[rd_ptr_q];

  byte_negate u_negate (
    .a (acc_q),
    .y (neg_acc)
  );

  always_comb begin
    sum = '0;
    r   = acc_q;
    c   = 1'b0;
    v   = 1'b0;
    unique case (head_op)
      OpLoad: begin
        r = head_opnd;
      end
      OpAdd: begin
        sum = {1'b0, acc_q} + {1'b0, head_opnd};
        r   = sum[7:0];
        c   = sum[8];
        v   = (acc_q[7] == head_opnd[7]) && (r[7] != acc_q[7]);
      end
      OpSub: begin
        // Carry out of acc + ~b + 1 is the inverted borrow
        sum = {1'b0, acc_q} + {1'b0, ~head_opnd} + 9'd1;
        r   = sum[7:0];
        c   = sum[8];
        v   = (acc_q[7] != head_opnd[7]) && (r[7] != acc_q[7]);
      end
      OpNeg: begin
        r = neg_acc;
        c = (acc_q == 8'h00);
        v = (acc_q == 8'h80);
      end
      default: begin
        r = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= 8'h00;
      res_valid_q <= 1'b0;
      flag_z_q    <= 1'b1;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      res_valid_q <= pop;
      if (pop) begin
        acc_q    <= r;
        flag_z_q <= (r == 8'h00);
        flag_n_q <= r[7];
        flag_c_q <= c;
        flag_v_q <= v;
      end
    end
  end

  assign acc       = acc_q;
  assign res_valid = res_valid_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign count     = count_q;

endmodule

// File: tb/tb_byte_accumulator.sv
// Scoreboard bench for byte_accumulator: directed ops push expected results,
// a negedge monitor pops and compares on every res_valid pulse.

module tb_byte_accumulator;

  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op;
  logic [7:0] operand;
  logic       hold;
  logic [7:0] acc;
  logic       res_valid;
  logic       flag_z, flag_n, flag_c, flag_v;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  // {acc, z, n, c, v}
  logic [11:0] exp_q[$];

  byte_accumulator #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .operand   (operand),
    .hold      (hold),
    .acc       (acc),
    .res_valid (res_valid),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_res_valid: got acc=%02h flags zncv=%b%b%b%b, required no pulse",
                 acc, flag_z, flag_n, flag_c, flag_v);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({acc, flag_z, flag_n, flag_c, flag_v} !== e) begin
          errors++;
          $display("FAIL result: got acc=%02h zncv=%b%b%b%b, required acc=%02h zncv=%b",
                   acc, flag_z, flag_n, flag_c, flag_v, e[11:4], e[3:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send(input logic [1:0] o, input logic [7:0] b,
                      input logic expect_res, input logic [11:0] e);
    int guard;
    op_valid = 1'b1;
    op       = o;
    operand  = b;
    guard    = 0;
    while (op_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got op_ready=%b, required 1", op_ready);
    end else if (expect_res) begin
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op       = 2'b00;
    operand  = 8'h00;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || count != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    hold  = 1'b0;
    idle();
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_acc", acc, 8'h00);
    check("reset_z", {7'd0, flag_z}, 8'd1);
    check("reset_ncv", {5'd0, flag_n, flag_c, flag_v}, 8'd0);
    check("reset_res_valid", {7'd0, res_valid}, 8'd0);
    check("reset_count", 8'(count), 8'd0);
    check("reset_op_ready", {7'd0, op_ready}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    check("op_ready_after_reset", {7'd0, op_ready}, 8'd1);

    // Equal subtract
    send(2'b00, 8'h05, 1'b1, {8'h05, 4'b0000});
    send(2'b10, 8'h05, 1'b1, {8'h00, 4'b1010});
    idle();
    drain();
    // Borrow
    send(2'b00, 8'h00, 1'b1, {8'h00, 4'b1000});
    send(2'b10, 8'h01, 1'b1, {8'hFF, 4'b0100});
    idle();
    drain();
    // Signed overflow
    send(2'b00, 8'h7F, 1'b1, {8'h7F, 4'b0000});
    send(2'b01, 8'h01, 1'b1, {8'h80, 4'b0101});
    idle();
    drain();
    // NEG corners
    send(2'b00, 8'h80, 1'b1, {8'h80, 4'b0100});
    send(2'b11, 8'h00, 1'b1, {8'h80, 4'b0101});
    send(2'b00, 8'h01, 1'b1, {8'h01, 4'b0000});
    send(2'b11, 8'h00, 1'b1, {8'hFF, 4'b0100});
    send(2'b00, 8'h00, 1'b1, {8'h00, 4'b1000});
    send(2'b11, 8'h00, 1'b1, {8'h00, 4'b1010});
    idle();
    drain();

    // Latency: accepted at edge k, result visible between k+1 and k+2
    op_valid = 1'b1;
    op       = 2'b00;
    operand  = 8'h3C;
    exp_q.push_back({8'h3C, 4'b0000});
    @(negedge clk);
    idle();
    check("latency_no_early_pulse", {7'd0, res_valid}, 8'd0);
    @(negedge clk);
    check("latency_acc", acc, 8'h3C);
    drain();

    // Full FIFO while held
    hold = 1'b1;
    send(2'b00, 8'h10, 1'b1, {8'h10, 4'b0000});
    send(2'b01, 8'h20, 1'b1, {8'h30, 4'b0000});
    send(2'b10, 8'h08, 1'b1, {8'h28, 4'b0010});
    send(2'b11, 8'h00, 1'b1, {8'hD8, 4'b0100});
    check("full_count", 8'(count), 8'd4);
    check("full_op_ready", {7'd0, op_ready}, 8'd0);
    op_valid = 1'b1;
    op       = 2'b01;
    operand  = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_count_blocked", 8'(count), 8'd4);
    end
    idle();
    hold   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) pulses++;
    end
    check("consecutive_pulses", 8'(pulses), 8'd4);
    check("full_final_acc", acc, 8'hD8);
    check("full_final_zn", {6'd0, flag_z, flag_n}, 8'b01);
    drain();

    // Reset with ops queued
    hold = 1'b1;
    send(2'b00, 8'h11, 1'b0, '0);
    send(2'b01, 8'h22, 1'b0, '0);
    send(2'b11, 8'h00, 1'b0, '0);
    idle();
    check("queued_count", 8'(count), 8'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_count", 8'(count), 8'd0);
    check("rst_mid_acc", acc, 8'h00);
    check("rst_mid_z", {7'd0, flag_z}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
